cb_inport: RTL and testbench

- Input-port unit that drives one crossbar input: buffers flits arriving from a link and raises a request plus destination port toward the crossbar's per-output mux controllers.
- Consumes that input's row of crossbar grants and forwards flits into the crossbar wormhole-style: the request is held from head flit to tail flit.
- One instance per crossbar input; PORT_N instances feed the crossbar's port/request vectors and receive its grant matrix.

---
 rtl/cb_inport.sv | 73 +++++++
 tb/tb_cb_inport.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cb_inport.sv
// cb_inport: buffers link flits in a small FIFO and forwards them wormhole-style into one crossbar input,
// holding the request from head transfer through tail transfer.
module cb_inport #(
  parameter int PORT_N = 5,
  parameter int PORT_W = 3,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_head_i,
  input  logic              in_tail_i,
  input  logic [PORT_W-1:0] in_dst_i,
  output logic              req_o,
  output logic [PORT_W-1:0] port_o,
  input  logic [PORT_N-1:0] grt_i,
  input  logic              dn_rdy_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_head_o,
  output logic              out_tail_o,
  output logic              drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = DATA_W + PORT_W + 2;
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;
  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [0:0] state;
  logic [PORT_W-1:0] route;
  logic f_head, f_tail, empty, push, pop, hit, xfer, drop;
  logic [PORT_W-1:0] f_dst;
  logic [DATA_W-1:0] f_data;
  assign {f_head, f_tail, f_dst, f_data} = mem[rp];
  assign empty = cnt == '0;
  assign in_rdy_o = cnt != (AW+1)'(DEPTH);
  assign push = in_vld_i & in_rdy_o;
  // only the grant bit of the held route counts; other bits belong to other arbitration
  assign hit = |(grt_i & (PORT_N'(1) << route));
  assign xfer = (state == ACTIVE) & hit & dn_rdy_i & ~empty;
  assign drop = (state == IDLE) & ~empty & ~f_head;
  assign pop = xfer | drop;
  assign req_o = state == ACTIVE;
  assign port_o = route;
  assign out_vld_o = xfer;
  assign out_data_o = xfer ? f_data : '0;
  assign out_head_o = xfer & f_head;
  assign out_tail_o = xfer & f_tail;
  assign drop_o = drop;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_head_i, in_tail_i, in_dst_i, in_data_i};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      state <= IDLE;
      route <= '0;
    end else begin
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (state == IDLE && !empty && f_head) begin
        state <= ACTIVE;
        route <= f_dst;
      end else if (xfer && f_tail) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cb_inport.sv
// tb_cb_inport: directed timing checks plus randomized traffic against a queue-based packet model.
module tb_cb_inport;
  localparam int PORT_N = 5, PORT_W = 3, DATA_W = 32, DEPTH = 4;
  typedef struct {bit [31:0] d; bit h; bit t; bit [2:0] dst;} flit_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_vld = 1'b0, in_head = 1'b0, in_tail = 1'b0, dn_rdy = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [PORT_W-1:0] in_dst = '0;
  logic [PORT_N-1:0] grt = '0;
  logic in_rdy, req, out_vld, out_head, out_tail, drop;
  logic [PORT_W-1:0] port;
  logic [DATA_W-1:0] out_data;
  int checks = 0, errors = 0;
  flit_t q[$];
  bit act = 1'b0, acc, adv;
  bit [2:0] route = '0, pdst;
  int rem = 0, idx = 0, len = 0;

  cb_inport #(.PORT_N(PORT_N), .PORT_W(PORT_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_data_i(in_data),
    .in_head_i(in_head), .in_tail_i(in_tail), .in_dst_i(in_dst), .req_o(req), .port_o(port),
    .grt_i(grt), .dn_rdy_i(dn_rdy), .out_vld_o(out_vld), .out_data_o(out_data),
    .out_head_o(out_head), .out_tail_o(out_tail), .drop_o(drop));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // checks outputs mid-cycle against the model, then advances the model across the clock edge
  task automatic step();
    bit ne, ex, ed, rdy;
    flit_t f;
    f = '{0, 0, 0, 0};
    @(negedge clk);
    ne = q.size() != 0;
    if (ne) f = q[0];
    rdy = q.size() != DEPTH;
    ex = act && grt[route] && dn_rdy && ne;
    ed = !act && ne && !f.h;
    chk("in_rdy", in_rdy, rdy);
    chk("req", req, act);
    if (act) chk("port", port, route);
    chk("out_vld", out_vld, ex);
    chk("drop", drop, ed);
    if (ex) begin
      chk("out_data", out_data, f.d);
      chk("out_head", out_head, f.h);
      chk("out_tail", out_tail, f.t);
    end
    acc = in_vld && rdy;
    if (rst) begin
      q.delete();
      act = 1'b0;
      route = '0;
    end else begin
      if (!act && ne && f.h) begin
        act = 1'b1;
        route = f.dst;
      end
      if (ed) void'(q.pop_front());
      if (ex) begin
        void'(q.pop_front());
        if (f.t) act = 1'b0;
      end
      if (acc) q.push_back('{in_data, in_head, in_tail, in_dst});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand();
    int r;
    rst = ($urandom % 400) == 0;
    dn_rdy = ($urandom % 4) != 0;
    r = $urandom % 10;
    grt = (r < 5 && act) ? (5'b00001 << route) : (r < 7) ? 5'b0 : (5'b00001 << ($urandom % 5));
    in_vld = ($urandom % 3) != 0;
    in_data = $urandom;
    adv = 1'b0;
    if (rem == 0 && ($urandom % 15) == 0) begin
      in_head = 1'b0;
      in_tail = 1'($urandom % 2);
      in_dst = 3'($urandom % 5);
    end else begin
      if (rem == 0) begin
        len = 1 + $urandom % 5;
        rem = len;
        idx = 0;
        pdst = 3'($urandom % 5);
      end
      in_head = idx == 0;
      in_tail = idx == len - 1;
      in_dst = pdst;
      adv = 1'b1;
    end
  endtask

  initial begin
    in_vld = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_dst = 3'd3; in_data = 32'h1234;
    repeat (2) step();
    rst = 1'b0; in_vld = 1'b0;
    step();
    chk("rst_rdy", in_rdy, 1'b1);
    chk("rst_req", req, 1'b0);
    chk("rst_port", port, 3'd0);
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_drop", drop, 1'b0);
    in_vld = 1'b1; in_head = 1'b1; in_tail = 1'b1; in_dst = 3'd3; in_data = 32'hA5;
    grt = 5'b01000; dn_rdy = 1'b1;
    step();
    in_vld = 1'b0;
    chk("sf_req_t1", req, 1'b0);
    step();
    chk("sf_req_t2", req, 1'b1);
    chk("sf_port", port, 3'd3);
    chk("sf_vld", out_vld, 1'b1);
    chk("sf_data", out_data, 32'hA5);
    step();
    chk("sf_req_off", req, 1'b0);
    chk("sf_vld_off", out_vld, 1'b0);
    in_vld = 1'b1; in_head = 1'b0; in_tail = 1'b1; in_data = 32'hBAD;
    step();
    in_vld = 1'b0;
    chk("orph_drop", drop, 1'b1);
    chk("orph_req", req, 1'b0);
    step();
    chk("orph_drop_end", drop, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_vld = 1'b1; in_head = i == 0; in_tail = i == 3; in_dst = 3'd1; in_data = 32'h100 + i;
      grt = 5'b00100;
      step();
    end
    in_vld = 1'b0;
    chk("full_rdy", in_rdy, 1'b0);
    chk("wrong_grt_vld", out_vld, 1'b0);
    chk("hold_req", req, 1'b1);
    grt = 5'b00010;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 3000; i++) begin
      drive_rand();
      step();
      if (acc && adv && !rst) begin
        idx++;
        rem--;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
